pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the pipelined CPU. It drives the `newPC` input of the program-counter register, which loads unconditionally on every clock. It arbitrates between sequential fetch, load-use stalls, jumps, taken branches, exceptions, exception return and halt. It also owns the boot and exception-drain sequencing, the IF/ID flush strobes and the EPC register.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, fetch address after reset
- EXC_VEC, 32'h0000_0080, exception handler entry address
- FLUSH_CYCLES, 2, cycles spent in FLUSH after an exception (legal range 1..7)

Ports (one clock; `reset` is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc_cur  in  32  current PC register output
- stall  in  1  load-use hazard; hold the PC
- jmp  in  1  jump resolved in ID
- jmp_target  in  32  jump destination
- br_taken  in  1  branch taken, resolved in ID
- br_target  in  32  branch destination
- exc_req  in  1  exception request
- eret  in  1  return from exception
- halt_req  in  1  halt/syscall-stop request
- newPC  out  32  next PC, combinational
- flush_if  out  1  squash the IF/ID register
- flush_id  out  1  squash the ID/EX register
- epc  out  32  exception PC
- busy  out  1  high in BOOT or FLUSH
- halted  out  1  high in HALT

## Operation
- States: BOOT, RUN, FLUSH, HALT. All outputs and state are driven from registered state plus the current inputs.
- Reset values: state=BOOT, flush counter=0, epc=0. During reset `newPC`=RESET_VEC, flush_if=1, flush_id=0, busy=1, halted=0.
- BOOT: newPC=RESET_VEC, flush_if=1. Goes to RUN at the next edge; all requests are ignored.
- RUN uses fixed priority, highest first:
  - exc_req: newPC=EXC_VEC; flush_if=flush_id=1; epc<=pc_cur; counter<=FLUSH_CYCLES-1; go to FLUSH.
  - eret: newPC=epc; flush_if=1.
  - halt_req: newPC=pc_cur; flush_if=flush_id=1; go to HALT.
  - stall: newPC=pc_cur; no flush. A jump or branch asserted in the same cycle is dropped; it is re-presented next cycle because ID holds.
  - jmp: newPC=jmp_target; flush_if=1.
  - br_taken: newPC=br_target; flush_if=1.
  - Otherwise: newPC=pc_cur+4.
- FLUSH: newPC=pc_cur (held at EXC_VEC); flush_if=flush_id=1; all requests masked. The counter decrements each cycle. When it reads 0, go to RUN at the next edge.
- HALT: newPC=pc_cur; flush_if=flush_id=1; halted=1. Only reset exits HALT.
- Arithmetic and width rules:
  - pc_cur+4 is 32-bit, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Bits [1:0] of every newPC source are forced to 0.

## Timing
- newPC is combinational. It appears in pc_cur one edge later, so a redirect has 1-cycle latency.
- epc, state and counter update on the same edge that the PC loads.
- An exception occupies 1 RUN cycle followed by exactly FLUSH_CYCLES FLUSH cycles. Sequential fetch from EXC_VEC resumes in the first RUN cycle after that.
- Reset asserted mid-FLUSH or mid-HALT forces BOOT immediately, asynchronously. epc clears to 0.
- exc_req and eret asserted together: the exception wins and epc takes pc_cur.

## Configuration
- PC_SEQ_EPC_EN defined: EPC register, eret path and epc capture are present.
- Undefined: eret is ignored and falls through to the next priority; epc is tied to 0.
- Undefined: exceptions still vector to EXC_VEC and run FLUSH, but capture nothing.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (BOOT/RUN/FLUSH/HALT);
  - the default RESET_VEC and EXC_VEC;
  - the PC increment constant 4.
- One sub-module, pc_seq_nextpc_mux: the purely combinational priority select and alignment of newPC and the flush strobes.
- The state register, counter and EPC stay in the top module.

## Test plan
- Reset release, pc_cur=0, no requests. Required: one BOOT cycle with newPC=0 and flush_if=1, then newPC=4, 8, 12 on successive cycles.
- pc_cur=0x40, stall=1 and jmp=1 with jmp_target=0x100. Required: newPC=0x40, no flush. Next cycle stall=0, jmp=1: newPC=0x100, flush_if=1.
- pc_cur=0x24, exc_req=1. Required: newPC=0x80; epc=0x24 after the edge; busy=1 with both flushes high for 2 cycles; then newPC=0x84.
- After the exception above, eret=1. Required: newPC=0x24, flush_if=1. Repeat with PC_SEQ_EPC_EN undefined: newPC=pc_cur+4 and epc=0.
- br_target=0x203, br_taken=1. Required: newPC=0x200. Separately, pc_cur=0xFFFF_FFFC with no request: required newPC=0.
- halt_req=1. Required: halted=1 and newPC holds pc_cur indefinitely. Reset asserted during FLUSH: state=BOOT, newPC=RESET_VEC and epc=0 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// No logic here: state enum, request bundle, default vectors, PC alignment helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    // Redirect/control requests, listed in RUN priority order (highest first).
    typedef struct packed {
        logic exc;
        logic eret;
        logic halt;
        logic stall;
        logic jmp;
        logic br;
    } pc_req_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
    localparam logic [31:0] PC_INC        = 32'd4;

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_nextpc_mux.sv
// Purpose: priority select of newPC and IF/ID flush strobes (eret path when PC_SEQ_EPC_EN is defined).
// Latency: purely combinational, zero cycles.
// Backpressure: none; stall simply selects the held PC.
module pc_seq_nextpc_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
    input  pc_state_e   state,
    input  pc_req_t     req,
    input  logic [31:0] pc_cur,
    input  logic [31:0] jmp_target,
    input  logic [31:0] br_target,
    input  logic [31:0] epc,
    output logic [31:0] new_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        take_exc,
    output logic        take_halt
);

    logic        eret_hit;
    logic [31:0] pc_raw;

`ifdef PC_SEQ_EPC_EN
    assign eret_hit = req.eret;
`else
    // Without an EPC there is nowhere to return to; eret falls through.
    logic unused_eret;
    assign eret_hit    = 1'b0;
    assign unused_eret = req.eret;
`endif

    always_comb begin
        pc_raw    = pc_cur + PC_INC;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        take_exc  = 1'b0;
        take_halt = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_raw   = RESET_VEC;
                flush_if = 1'b1;
            end
            ST_RUN: begin
                if (req.exc) begin
                    pc_raw   = EXC_VEC;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    take_exc = 1'b1;
                end else if (eret_hit) begin
                    pc_raw   = epc;
                    flush_if = 1'b1;
                end else if (req.halt) begin
                    pc_raw    = pc_cur;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                    take_halt = 1'b1;
                end else if (req.stall) begin
                    // ID holds, so a concurrent jmp/br is re-presented next cycle.
                    pc_raw = pc_cur;
                end else if (req.jmp) begin
                    pc_raw   = jmp_target;
                    flush_if = 1'b1;
                end else if (req.br) begin
                    pc_raw   = br_target;
                    flush_if = 1'b1;
                end
            end
            ST_FLUSH, ST_HALT: begin
                pc_raw   = pc_cur;
                flush_if = 1'b1;
                flush_id = 1'b1;
            end
            default: begin
                pc_raw = pc_cur;
            end
        endcase
    end

    assign new_pc = pc_align(pc_raw);

endmodule

// File: rtl/pc_sequencer.sv
// Purpose: next-PC controller with BOOT/RUN/FLUSH/HALT sequencing; EPC and eret present only with PC_SEQ_EPC_EN.
// Latency: newPC combinational, redirect visible in pc_cur one edge later; exception costs 1 RUN + FLUSH_CYCLES cycles.
// Backpressure: stall holds the PC; requests are masked while busy or halted.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC    = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC      = DEF_EXC_VEC,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        halt_req,
    output logic [31:0] newPC,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic        busy,
    output logic        halted
);

    pc_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    pc_req_t    req;
    logic       take_exc;
    logic       take_halt;

    assign req = '{exc: exc_req, eret: eret, halt: halt_req,
                   stall: stall, jmp: jmp, br: br_taken};

    pc_seq_nextpc_mux #(
        .RESET_VEC (RESET_VEC),
        .EXC_VEC   (EXC_VEC)
    ) u_mux (
        .state      (state_q),
        .req        (req),
        .pc_cur     (pc_cur),
        .jmp_target (jmp_target),
        .br_target  (br_target),
        .epc        (epc),
        .new_pc     (newPC),
        .flush_if   (flush_if),
        .flush_id   (flush_id),
        .take_exc   (take_exc),
        .take_halt  (take_halt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (take_exc) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES - 1);
                end else if (take_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_FLUSH: begin
                // Counter reaching zero marks the last FLUSH cycle.
                if (cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_SEQ_EPC_EN
    logic [31:0] epc_q, epc_d;

    always_comb begin
        epc_d = epc_q;
        if (take_exc) begin
            epc_d = pc_cur;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q <= 32'd0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`else
    assign epc = 32'd0;
`endif

    assign busy   = (state_q == ST_BOOT) || (state_q == ST_FLUSH);
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: reset/boot, RUN priority table, exception/eret/halt/reset sequences, randomized run vs reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;
    localparam int          FC = 2;
`ifdef PC_SEQ_EPC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur, jmp_target, br_target;
    logic        stall, jmp, br_taken, exc_req, eret, halt_req;
    logic [31:0] newPC, epc;
    logic        flush_if, flush_id, busy, halted;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .stall      (stall),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .halt_req   (halt_req),
        .newPC      (newPC),
        .flush_if   (flush_if),
        .flush_id   (flush_id),
        .epc        (epc),
        .busy       (busy),
        .halted     (halted)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic clr();
        stall = 1'b0; jmp = 1'b0; br_taken = 1'b0;
        exc_req = 1'b0; eret = 1'b0; halt_req = 1'b0;
        jmp_target = 32'd0; br_target = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: boot pending flag, remaining flush cycles, halted flag, saved EPC.
    bit          m_boot;
    bit          m_halt;
    int          m_fl;
    logic [31:0] m_epc;

    task automatic model_step();
        logic [31:0] e_pc;
        logic        e_fi, e_fd;
        if (reset) begin
            m_boot = 1'b1; m_halt = 1'b0; m_fl = 0; m_epc = 32'd0;
        end
        e_fi = 1'b0; e_fd = 1'b0;
        if (m_boot) begin
            e_pc = RV; e_fi = 1'b1;
        end else if (m_halt || m_fl > 0) begin
            e_pc = pc_cur; e_fi = 1'b1; e_fd = 1'b1;
        end else if (exc_req) begin
            e_pc = EV; e_fi = 1'b1; e_fd = 1'b1;
        end else if (EPC_EN && eret) begin
            e_pc = m_epc; e_fi = 1'b1;
        end else if (halt_req) begin
            e_pc = pc_cur; e_fi = 1'b1; e_fd = 1'b1;
        end else if (stall) begin
            e_pc = pc_cur;
        end else if (jmp) begin
            e_pc = jmp_target; e_fi = 1'b1;
        end else if (br_taken) begin
            e_pc = br_target; e_fi = 1'b1;
        end else begin
            e_pc = pc_cur + 32'd4;
        end
        e_pc = e_pc & ~32'h3;
        chk32("rand_newPC", newPC, e_pc);
        chk1("rand_flush_if", flush_if, e_fi);
        chk1("rand_flush_id", flush_id, e_fd);
        chk1("rand_busy", busy, m_boot || (m_fl > 0));
        chk1("rand_halted", halted, m_halt);
        chk32("rand_epc", epc, EPC_EN ? m_epc : 32'd0);
        if (!reset) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_halt) begin
                m_halt = 1'b1;
            end else if (m_fl > 0) begin
                m_fl--;
            end else if (exc_req) begin
                m_fl = FC;
                if (EPC_EN) m_epc = pc_cur;
            end else if (!(EPC_EN && eret) && halt_req) begin
                m_halt = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        st, jp, br;
        logic [31:0] jt, bt;
        logic [31:0] exp_pc;
        logic        exp_fi;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] exp_epc;
        logic [31:0] exp_pc;
        logic        exp_fi;

        tbl.push_back('{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0104, 1'b0});
        tbl.push_back('{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0});
        tbl.push_back('{32'h0000_0040, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_0040, 1'b0});
        tbl.push_back('{32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_0100, 1'b1});
        tbl.push_back('{32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h0, 32'h203, 32'h0000_0200, 1'b1});
        tbl.push_back('{32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'h300, 32'h400, 32'h0000_0300, 1'b1});
        tbl.push_back('{32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0014, 1'b0});
        tbl.push_back('{32'h0000_0050, 1'b1, 1'b0, 1'b1, 32'h0, 32'h600, 32'h0000_0050, 1'b0});
        tbl.push_back('{32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'h107, 32'h0, 32'h0000_0104, 1'b1});

        // Reset and boot
        clr();
        reset = 1'b1;
        pc_cur = 32'd0;
        @(negedge clk);
        chk32("rst_newPC", newPC, RV);
        chk1("rst_flush_if", flush_if, 1'b1);
        chk1("rst_flush_id", flush_id, 1'b0);
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_halted", halted, 1'b0);
        chk32("rst_epc", epc, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk32("boot_newPC", newPC, RV);
        chk1("boot_flush_if", flush_if, 1'b1);
        chk1("boot_busy", busy, 1'b1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            pc_cur = 32'(i * 4);
            @(negedge clk);
            chk32("seq_newPC", newPC, 32'((i + 1) * 4));
            chk1("seq_flush_if", flush_if, 1'b0);
            chk1("seq_busy", busy, 1'b0);
            next_cycle();
        end

        // RUN-state priority table
        foreach (tbl[k]) begin
            clr();
            pc_cur = tbl[k].pc; stall = tbl[k].st; jmp = tbl[k].jp; br_taken = tbl[k].br;
            jmp_target = tbl[k].jt; br_target = tbl[k].bt;
            @(negedge clk);
            chk32("tbl_newPC", newPC, tbl[k].exp_pc);
            chk1("tbl_flush_if", flush_if, tbl[k].exp_fi);
            chk1("tbl_flush_id", flush_id, 1'b0);
            chk1("tbl_busy", busy, 1'b0);
            next_cycle();
        end

        // Exception with masked requests during FLUSH
        clr();
        exp_epc = EPC_EN ? 32'h24 : 32'h0;
        pc_cur = 32'h24; exc_req = 1'b1;
        @(negedge clk);
        chk32("exc_newPC", newPC, EV);
        chk1("exc_flush_if", flush_if, 1'b1);
        chk1("exc_flush_id", flush_id, 1'b1);
        next_cycle();
        clr();
        pc_cur = EV; jmp = 1'b1; jmp_target = 32'h500;
        @(negedge clk);
        chk32("fl1_newPC", newPC, EV);
        chk1("fl1_busy", busy, 1'b1);
        chk1("fl1_flush_id", flush_id, 1'b1);
        chk32("fl1_epc", epc, exp_epc);
        next_cycle();
        clr();
        exc_req = 1'b1;
        @(negedge clk);
        chk32("fl2_newPC", newPC, EV);
        chk1("fl2_busy", busy, 1'b1);
        chk1("fl2_flush_if", flush_if, 1'b1);
        next_cycle();
        clr();
        @(negedge clk);
        chk32("post_exc_newPC", newPC, 32'h84);
        chk1("post_exc_busy", busy, 1'b0);
        chk1("post_exc_flush_if", flush_if, 1'b0);
        next_cycle();

        // Exception return
        pc_cur = 32'h84; eret = 1'b1;
`ifdef PC_SEQ_EPC_EN
        exp_pc = 32'h24; exp_fi = 1'b1;
`else
        exp_pc = 32'h88; exp_fi = 1'b0;
`endif
        @(negedge clk);
        chk32("eret_newPC", newPC, exp_pc);
        chk1("eret_flush_if", flush_if, exp_fi);
        chk32("eret_epc", epc, exp_epc);
        next_cycle();

        // exc + eret together, then reset mid-FLUSH
        clr();
        pc_cur = 32'h60; exc_req = 1'b1; eret = 1'b1;
        @(negedge clk);
        chk32("exc_eret_newPC", newPC, EV);
        next_cycle();
        clr();
        pc_cur = EV;
        @(negedge clk);
        chk32("exc_eret_epc", epc, EPC_EN ? 32'h60 : 32'h0);
        chk1("exc_eret_busy", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk32("rst_fl_newPC", newPC, RV);
        chk1("rst_fl_flush_id", flush_id, 1'b0);
        chk1("rst_fl_busy", busy, 1'b1);
        chk32("rst_fl_epc", epc, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Halt holds indefinitely
        pc_cur = 32'h30; halt_req = 1'b1;
        @(negedge clk);
        chk32("halt_newPC", newPC, 32'h30);
        chk1("halt_flush_id", flush_id, 1'b1);
        chk1("halt_pre_halted", halted, 1'b0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            clr();
            exc_req = 1'($urandom_range(1)); jmp = 1'b1; jmp_target = 32'h700;
            @(negedge clk);
            chk32("halted_newPC", newPC, 32'h30);
            chk1("halted_flag", halted, 1'b1);
            chk1("halted_flush_if", flush_if, 1'b1);
            next_cycle();
        end
        reset = 1'b1;
        #1;
        chk1("halt_rst_halted", halted, 1'b0);
        chk32("halt_rst_newPC", newPC, RV);
        next_cycle();

        // Randomized run against reference model
        for (int c = 0; c < 1500; c++) begin
            reset      = (c < 2) || ($urandom_range(99) == 0) || (m_halt && $urandom_range(7) == 0);
            pc_cur     = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom;
            stall      = ($urandom_range(5) == 0);
            jmp        = ($urandom_range(4) == 0);
            br_taken   = ($urandom_range(4) == 0);
            exc_req    = ($urandom_range(11) == 0);
            eret       = ($urandom_range(9) == 0);
            halt_req   = ($urandom_range(39) == 0);
            jmp_target = $urandom;
            br_target  = $urandom;
            @(negedge clk);
            model_step();
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
